// File: rtl/apb_requester_if.sv
// Signal bundle between the local command/response port and the APB completer bus.
// The master modport is the requester's view: it drives the APB request and the response.
interface apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 2
);
  localparam int SEL_W = (NSEL > 1) ? $clog2(NSEL) : 1;

  // Local command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [SEL_W-1:0]  cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Local response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB bus
  logic [ADDR_W-1:0] PADDR;
  logic [NSEL-1:0]   PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: one local command becomes one APB transfer and one response.
// A wait-state counter aborts transfers to a completer that never raises PREADY.
module apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NSEL           = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_requester_if.master  bus
);

  localparam int                CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit                TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [NSEL-1:0]   SEL_ONE     = NSEL'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q,       state_d;
  logic [ADDR_W-1:0] paddr_q,       paddr_d;
  logic [NSEL-1:0]   psel_q,        psel_d;
  logic              penable_q,     penable_d;
  logic              pwrite_q,      pwrite_d;
  logic [DATA_W-1:0] pwdata_q,      pwdata_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = SETUP;
          paddr_d    = bus.cmd_addr;
          pwrite_d   = bus.cmd_write;
          pwdata_d   = bus.cmd_write ? bus.cmd_wdata : '0;
          psel_d     = SEL_ONE << bus.cmd_sel;
          wait_cnt_d = '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PREADY is tested first so a completion in the timeout cycle is still honoured.
        if (bus.PREADY) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_VAL)) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

endmodule
